// File: rtl/prv32_div_unit_if.sv
// Request/response bundle between the EX-stage operand path and the divider.
interface prv32_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/prv32_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish in one cycle.
module prv32_div_unit #(
    parameter int WIDTH = 32
) (
    input logic              clk,
    input logic              rst,
    prv32_div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       op_q;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] divisor, rem, quo, result_q;
    logic [CW-1:0]    count;

    // op[0] selects unsigned, op[1] selects remainder.
    logic             is_signed, neg_a, neg_b, div_zero, ovf;
    logic [WIDTH-1:0] mag_a, mag_b, special_res;

    assign is_signed = ~bus.op[0];
    assign neg_a     = is_signed & bus.a[WIDTH-1];
    assign neg_b     = is_signed & bus.b[WIDTH-1];
    assign mag_a     = neg_a ? -bus.a : bus.a;
    assign mag_b     = neg_b ? -bus.b : bus.b;
    assign div_zero  = (bus.b == '0);
    assign ovf       = is_signed && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        special_res = '0;
        if (div_zero)
            special_res = bus.op[1] ? bus.a : '1;
        else if (ovf)
            special_res = bus.op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
    end

    // The shifted remainder needs WIDTH+1 bits: it may exceed WIDTH bits before subtracting.
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] rem_next, quo_next, final_res;

    assign shifted   = {rem, quo[WIDTH-1]};
    assign trial     = shifted - {1'b0, divisor};
    assign rem_next  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_next  = {quo[WIDTH-2:0], ~trial[WIDTH]};
    assign final_res = op_q[1] ? (sign_a ? -rem_next : rem_next)
                               : ((sign_a ^ sign_b) ? -quo_next : quo_next);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            op_q     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            divisor  <= '0;
            rem      <= '0;
            quo      <= '0;
            count    <= '0;
            result_q <= '0;
        end else if (bus.flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        sign_a  <= neg_a;
                        sign_b  <= neg_b;
                        divisor <= mag_b;
                        if (div_zero || ovf) begin
                            result_q <= special_res;
                            state    <= DONE;
                        end else begin
                            rem   <= '0;
                            quo   <= mag_a;
                            count <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH-1)) begin
                        result_q <= final_res;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
endmodule
